tick_capture: RTL
=================

TICK_CAPTURE -- requirements
Module: tick_capture

Interface
REQ-001 Parameter N, default 8: width of counter value q.
REQ-002 Parameter W, default 8: width of the wrap-event counter.
REQ-003 Parameter DEPTH, default 4: capture FIFO depth, power of 2, at least 2.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 reset  in  1  one clock; reset is synchronous and active-low.
REQ-006 max_tick  in  1  status from the upstream counter; high while the counter sits at its maximum value.
REQ-007 q  in  N  current upstream counter value.
REQ-008 cap  in  1  capture strobe; sampled every cycle.
REQ-009 clr  in  1  synchronous clear of the wrap counter and the overflow flag.
REQ-010 rd_ready  in  1  consumer accepts the head entry.
REQ-011 rd_valid  out  1  FIFO is non-empty; head entry is presented on rd_data.
REQ-012 rd_data  out  W+N  head entry, {wrap_cnt, q}.
REQ-013 full  out  1  FIFO holds DEPTH entries.
REQ-014 ovf  out  1  sticky flag; a capture was dropped.
REQ-015 wrap_cnt  out  W  running count of max_tick rising edges.

Function
REQ-016 The block SHALL detect a max_tick rising edge when max_tick=1 and the registered copy max_tick_d=0.
REQ-017 On each detected edge, wrap_cnt SHALL increment by 1, modulo 2^W: all-ones wraps to 0 without setting a flag.
REQ-018 A max_tick that stays high for multiple cycles (upstream counter held at its maximum) SHALL count once.
REQ-019 A capture request SHALL occur when cap=1, regardless of the cap value in the previous cycle.
REQ-020 On a capture request, the entry {wrap_cnt, q} SHALL be formed from the values present in that cycle, using the pre-increment wrap_cnt, and written at the tail on the next clock edge.
REQ-021 A pop SHALL occur when rd_valid=1 and rd_ready=1; the head SHALL advance on that clock edge.
REQ-022 rd_data SHALL be driven from storage at the head pointer; it SHALL be stable while rd_valid=1 and rd_ready=0.
REQ-023 Write-to-read latency SHALL be 1 cycle: an entry captured in cycle t is visible with rd_valid=1 in cycle t+1.
REQ-024 Capture when not full: entry written; count +1 (unless a simultaneous pop occurs).
REQ-025 Capture when full with no pop in the same cycle: entry dropped; FIFO unchanged; ovf set to 1 on the next edge.
REQ-026 Capture when full with a pop in the same cycle: both operations occur; count stays DEPTH; ovf is not set.
REQ-027 Pop when empty is impossible, because rd_valid=0; rd_ready SHALL be ignored.
REQ-028 Capture and pop in the same cycle when not full: count unchanged.
REQ-029 Pointers SHALL be log2(DEPTH) bits and wrap naturally.
REQ-030 full and empty status SHALL be derived from a log2(DEPTH)+1-bit occupancy counter.
REQ-031 full and rd_valid SHALL be registered-state decodes with no combinational path from cap or rd_ready.
REQ-032 clr=1 SHALL set wrap_cnt=0 and ovf=0 on the next edge.
REQ-033 An edge detected while clr=1 SHALL be discarded.
REQ-034 clr SHALL NOT affect FIFO contents.
REQ-035 A capture in the same cycle as clr SHALL store the pre-clear wrap_cnt.
REQ-036 ovf SHALL remain 1 until clr or reset.

Reset
REQ-037 While reset=0 at a clock edge, the following SHALL be cleared: wrap_cnt=0, ovf=0, pointers=0, count=0, max_tick_d=0, rd_valid=0, full=0.
REQ-038 Reset SHALL take precedence over clr, cap and rd_ready.
REQ-039 Reset asserted mid-operation SHALL discard all buffered entries.
REQ-040 Storage array contents need not be reset; rd_data is don't-care while rd_valid=0.
REQ-041 If max_tick=1 during the first cycle after reset release, it SHALL count as a rising edge.

Verification
REQ-042 Edge counting (N=8, W=8): hold max_tick high 5 cycles, low 1 cycle, high 1 cycle -> wrap_cnt=2.
REQ-043 Wrap-around: 256 single-cycle max_tick pulses starting from wrap_cnt=0 -> wrap_cnt=0.
REQ-044 Capture timing: cap=1 with q=8'h3C, wrap_cnt=8'h05, and max_tick rising in the same cycle -> next cycle rd_valid=1, rd_data=16'h053C, wrap_cnt=8'h06.
REQ-045 Overflow: DEPTH=4; 5 captures with rd_ready=0 -> full=1, ovf=1; 4 pops yield the first 4 entries in order; afterwards rd_valid=0.
REQ-046 Full plus simultaneous push/pop: FIFO full, cap=1 and rd_ready=1 for 3 cycles -> full stays 1, ovf=0, output order preserved.
REQ-047 Reset mid-stream: 2 entries buffered, ovf=1, reset=0 for 1 cycle -> rd_valid=0, full=0, ovf=0, wrap_cnt=0; clr=1 with pending entries clears only wrap_cnt and ovf.

Source files
------------

// File: rtl/tick_capture.sv
// ----------------------------------------------------------------------------
// tick_capture
//
// This block watches an upstream free-running counter and records snapshots of
// it into a small FIFO.
//   * It counts the rising edges of the upstream max_tick status in wrap_cnt.
//     The count is modulo 2^W and has no overflow indication.
//   * On each cap strobe it pushes the entry {wrap_cnt, q} into a DEPTH-entry
//     FIFO. The entry uses the wrap count as it stands in the capture cycle,
//     before any increment in that cycle.
//   * The consumer drains the FIFO with a valid/ready handshake.
//   * A capture that finds the FIFO full, with no pop in the same cycle, is
//     dropped. The drop sets the sticky ovf flag.
//
// Ports
//   clk       in   1     rising-edge clock
//   reset     in   1     synchronous, active-low reset
//   max_tick  in   1     upstream counter is at its maximum value
//   q         in   N     upstream counter value
//   cap       in   1     capture strobe, level sampled every cycle
//   clr       in   1     clears wrap_cnt and ovf; FIFO contents are kept
//   rd_ready  in   1     consumer accepts the head entry
//   rd_valid  out  1     FIFO is non-empty
//   rd_data   out  W+N   head entry {wrap_cnt, q}
//   full      out  1     FIFO holds DEPTH entries
//   ovf       out  1     sticky: at least one capture was dropped
//   wrap_cnt  out  W     running count of max_tick rising edges
// ----------------------------------------------------------------------------
module tick_capture #(
    parameter int N     = 8,
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           max_tick,
    input  logic [N-1:0]   q,
    input  logic           cap,
    input  logic           clr,
    input  logic           rd_ready,
    output logic           rd_valid,
    output logic [W+N-1:0] rd_data,
    output logic           full,
    output logic           ovf,
    output logic [W-1:0]   wrap_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic             max_tick_d;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic [W+N-1:0]   mem [DEPTH];

    logic             tick_edge;
    logic             pop;
    logic             push;
    logic             drop;

    // A rising edge is max_tick high now and low in the previous cycle.
    // max_tick_d resets to 0, so a max_tick that is already high in the
    // first cycle after reset counts as an edge.
    assign tick_edge = max_tick & ~max_tick_d;

    // rd_valid and full decode only from the registered occupancy, so
    // neither output has a combinational path from cap or rd_ready.
    assign rd_valid = (count != '0);
    assign full     = (count == FULL_CNT);

    // When the FIFO is full, a pop in the same cycle frees the slot that the
    // capture writes. rd_ready is ignored while the FIFO is empty.
    assign pop  = rd_valid & rd_ready;
    assign push = cap & (~full | pop);
    assign drop = cap & full & ~pop;

    assign rd_data = mem[rd_ptr];

    // Edge detector and wrap counter. clr overrides an edge in the same
    // cycle, so that edge is lost.
    always_ff @(posedge clk) begin
        if (!reset) begin
            max_tick_d <= 1'b0;
            wrap_cnt   <= '0;
        end else begin
            max_tick_d <= max_tick;
            if (clr) begin
                wrap_cnt <= '0;
            end else if (tick_edge) begin
                wrap_cnt <= wrap_cnt + W'(1);
            end
        end
    end

    // Sticky overflow flag. Only clr or reset clear it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            ovf <= 1'b0;
        end else if (clr) begin
            ovf <= 1'b0;
        end else if (drop) begin
            ovf <= 1'b1;
        end
    end

    // FIFO control. The pointers wrap at DEPTH because DEPTH is a power of 2.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset. The entry holds the wrap count from before any
    // increment or clr in the capture cycle.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {wrap_cnt, q};
        end
    end

endmodule
